sdpram_bist_ctrl: RTL and testbench
===================================

// Module: sdpram_bist_ctrl
// PURPOSE
//   Synthesizable, self-checking BIST controller for the simple-dual-port RAM IPs (ICACHE/DCACHE tag and data arrays).
//   Writes a selectable pattern to every address, reads every address back and compares against the expected value.
//   Supports read latency 1 (unregistered output) or 2 (output register); reports pass/fail, error count and first failing address.
//   Both RAM ports run on wr_clk. Sits beside the RAM as its test driver, on board or in simulation.
// PARAMETERS
//   ADDR_WIDTH     8   RAM address width; depth N = 2**ADDR_WIDTH
//   DATA_WIDTH     21  RAM data width (1..1152)
//   RD_LATENCY     1   cycles from rd_addr/rd_en to valid rd_data; legal values 1 or 2
//   ERR_CNT_WIDTH  3   width of the saturating error counter
// PORTS
//   wr_clk          in   1               clock for the controller and both RAM ports
//   tb_wr_rst       in   1               asynchronous reset, active-high
//   start           in   1               one-cycle start pulse; sampled in IDLE or DONE only
//   mode            in   2               pattern select; latched when start is accepted
//   ram_wr_en       out  1               RAM write enable
//   ram_wr_addr     out  ADDR_WIDTH      RAM write address
//   ram_wr_data     out  DATA_WIDTH      RAM write data
//   ram_rd_en       out  1               read-request qualifier (drives the RAM clock enable when one is fitted)
//   ram_rd_addr     out  ADDR_WIDTH      RAM read address
//   ram_rd_data     in   DATA_WIDTH      RAM read data
//   busy            out  1               high from start acceptance until DONE
//   done            out  1               high in DONE, held until the next start or reset
//   pass            out  1               done && (err_cnt == 0)
//   err_cnt         out  ERR_CNT_WIDTH   mismatch count; saturates at all-ones
//   first_err_addr  out  ADDR_WIDTH      read address of the first mismatch; 0 if none
// BEHAVIOUR
//   Reset: every output is 0, state is IDLE, the compare pipe is cleared. Effect is immediate (asynchronous), including mid-run.
//   FSM: IDLE -start-> WRITE -(addr==N-1)-> GAP (1 cycle) -> READ -(addr==N-1)-> DRAIN (RD_LATENCY cycles) -> DONE -start-> WRITE.
//   start in DONE clears err_cnt, first_err_addr, done and pass, then begins WRITE. start in any other non-IDLE state is ignored.
//   WRITE: ram_wr_en=1 for exactly N consecutive cycles; ram_wr_addr = 0..N-1; ram_wr_data = pat(mode, addr).
//   READ: ram_rd_en=1 for exactly N consecutive cycles; ram_rd_addr = 0..N-1.
//   Each read pushes {valid, addr, pat(addr)} into a pipe of depth RD_LATENCY.
//   When a valid entry reaches the pipe output, ram_rd_data is compared to the expected value in the same cycle.
//   On mismatch: err_cnt increments unless already all-ones. first_err_addr is loaded only when err_cnt==0.
//   All outputs are registered. busy rises the cycle after start is sampled; run length = 2N+1+RD_LATENCY cycles; done rises the next cycle.
//   pat(mode, a), where a = address, D = DATA_WIDTH:
//     mode 0: {D{1}} - a (descending count from all-ones)
//     mode 1: a, zero-extended or truncated to D
//     mode 2: checkerboard; a[0]==0 -> ...0101, a[0]==1 -> ...1010
//     mode 3: walking one; 1 << (a mod D)
//   Wrap-around: the address counter is ADDR_WIDTH+1 bits wide internally, so the terminal test is exact; no aliasing at N-1.
//   Outside WRITE/READ, ram_wr_en, ram_rd_en and both address outputs are 0. ram_wr_data is 0 outside WRITE.
// TESTING (bench uses a behavioural SDPRAM model with selectable output register and fault injection)
//   T1 default params, mode 0, ideal RAM -> addr 0 written 0x1FFFFF, addr 255 written 0x1FFF00; done after 514 busy cycles; pass=1, err_cnt=0.
//   T2 model flips bit 4 at addr 0x37 -> err_cnt=1, first_err_addr=0x37, pass=0.
//   T3 model stuck-at-0 on data bit 0, mode 0 -> 128 mismatches; err_cnt saturates at 3'b111; first_err_addr=0x00.
//   T4 RD_LATENCY=2 with registered-output model -> pass=1.
//      RD_LATENCY=1 against the same model -> pass=0.
//   T5 tb_wr_rst pulsed while ram_wr_addr=0x80 -> ram_wr_en=0 and busy=0 with no clock edge; next start gives a clean full run, pass=1.
//   T6 mode 3, start pulsed again mid-READ -> ignored, run unchanged; addr 22 written 0x000002; pass=1.

Source files
------------

// File: rtl/sdpram_bist_ctrl.sv
// March-free BIST driver for simple-dual-port RAMs: writes a pattern everywhere, reads it
// back through a latency-matched expectation pipe and records mismatches.
module sdpram_bist_ctrl #(
    parameter int unsigned ADDR_WIDTH    = 8,
    parameter int unsigned DATA_WIDTH    = 21,
    parameter int unsigned RD_LATENCY    = 1,
    parameter int unsigned ERR_CNT_WIDTH = 3
) (
    input  logic                     wr_clk,
    input  logic                     tb_wr_rst,
    input  logic                     start,
    input  logic [1:0]               mode,
    output logic                     ram_wr_en,
    output logic [ADDR_WIDTH-1:0]    ram_wr_addr,
    output logic [DATA_WIDTH-1:0]    ram_wr_data,
    output logic                     ram_rd_en,
    output logic [ADDR_WIDTH-1:0]    ram_rd_addr,
    input  logic [DATA_WIDTH-1:0]    ram_rd_data,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt,
    output logic [ADDR_WIDTH-1:0]    first_err_addr
);

    localparam int unsigned CW    = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    localparam logic [CW-1:0]            LAST_ADDR  = CW'(DEPTH - 1);
    localparam logic [CW-1:0]            DRAIN_LAST = CW'(RD_LATENCY - 1);
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX    = '1;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StGap,
        StRead,
        StDrain,
        StDone
    } state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_inc;
    logic [1:0]      mode_q;

    logic [RD_LATENCY-1:0]                 pipe_vld;
    logic [RD_LATENCY-1:0][ADDR_WIDTH-1:0] pipe_addr;
    logic [RD_LATENCY-1:0][DATA_WIDTH-1:0] pipe_exp;
    logic                                  mismatch;

    function automatic logic [DATA_WIDTH-1:0] pat(input logic [1:0] md,
                                                  input logic [ADDR_WIDTH-1:0] a);
        logic [DATA_WIDTH-1:0] p;
        p = '0;
        case (md)
            2'd0: p = {DATA_WIDTH{1'b1}} - DATA_WIDTH'(a);
            2'd1: p = DATA_WIDTH'(a);
            2'd2: begin
                for (int i = 0; i < int'(DATA_WIDTH); i++) begin
                    p[i] = ((i % 2) == 0) ^ a[0];
                end
            end
            default: p = DATA_WIDTH'(1) << (32'(a) % DATA_WIDTH);
        endcase
        return p;
    endfunction

    always_comb begin
        cnt_inc  = cnt_q + 1'b1;
        mismatch = pipe_vld[RD_LATENCY-1] && (ram_rd_data != pipe_exp[RD_LATENCY-1]);
    end

    // Expectation pipe: entry k holds the read issued k+1 cycles ago.
    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            pipe_vld  <= '0;
            pipe_addr <= '0;
            pipe_exp  <= '0;
        end else begin
            pipe_vld[0]  <= ram_rd_en;
            pipe_addr[0] <= ram_rd_addr;
            pipe_exp[0]  <= pat(mode_q, ram_rd_addr);
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
                pipe_exp[i]  <= pipe_exp[i-1];
            end
        end
    end

    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            mode_q         <= '0;
            ram_wr_en      <= 1'b0;
            ram_wr_addr    <= '0;
            ram_wr_data    <= '0;
            ram_rd_en      <= 1'b0;
            ram_rd_addr    <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
        end else begin
            if (mismatch) begin
                if (err_cnt != ERR_MAX) begin
                    err_cnt <= err_cnt + 1'b1;
                end
                if (err_cnt == '0) begin
                    first_err_addr <= pipe_addr[RD_LATENCY-1];
                end
            end

            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q        <= StWrite;
                        mode_q         <= mode;
                        cnt_q          <= '0;
                        ram_wr_en      <= 1'b1;
                        ram_wr_addr    <= '0;
                        ram_wr_data    <= pat(mode, '0);
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        err_cnt        <= '0;
                        first_err_addr <= '0;
                    end
                end
                StWrite: begin
                    if (cnt_q == LAST_ADDR) begin
                        state_q     <= StGap;
                        cnt_q       <= '0;
                        ram_wr_en   <= 1'b0;
                        ram_wr_addr <= '0;
                        ram_wr_data <= '0;
                    end else begin
                        cnt_q       <= cnt_inc;
                        ram_wr_addr <= cnt_inc[ADDR_WIDTH-1:0];
                        ram_wr_data <= pat(mode_q, cnt_inc[ADDR_WIDTH-1:0]);
                    end
                end
                StGap: begin
                    state_q     <= StRead;
                    cnt_q       <= '0;
                    ram_rd_en   <= 1'b1;
                    ram_rd_addr <= '0;
                end
                StRead: begin
                    if (cnt_q == LAST_ADDR) begin
                        state_q     <= StDrain;
                        cnt_q       <= '0;
                        ram_rd_en   <= 1'b0;
                        ram_rd_addr <= '0;
                    end else begin
                        cnt_q       <= cnt_inc;
                        ram_rd_addr <= cnt_inc[ADDR_WIDTH-1:0];
                    end
                end
                StDrain: begin
                    // The last compare lands in the final drain cycle, so fold it into pass.
                    if (cnt_q == DRAIN_LAST) begin
                        state_q <= StDone;
                        cnt_q   <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (err_cnt == '0) && !mismatch;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sdpram_bist_ctrl.sv
// Scoreboard bench: two controllers (read latency 1 and 2) drive behavioural SDPRAMs with
// fault injection; run outcomes are predicted from the pattern rules and checked on done.
module tb_sdpram_bist_ctrl;

    localparam int AW = 8;
    localparam int DW = 21;
    localparam int N  = 256;

    typedef struct {
        bit pass;
        int err;
        int first;
        bit chk_first;
    } exp_t;

    logic          wr_clk    = 1'b0;
    logic          tb_wr_rst = 1'b0;
    logic          start     = 1'b0;
    logic [1:0]    mode      = 2'd0;

    logic          wr_en0, rd_en0, busy0, done0, pass0;
    logic [AW-1:0] wr_addr0, rd_addr0, fea0;
    logic [DW-1:0] wr_data0, rd_data0;
    logic [2:0]    err0;
    logic          wr_en1, rd_en1, busy1, done1, pass1;
    logic [AW-1:0] wr_addr1, rd_addr1, fea1;
    logic [DW-1:0] wr_data1, rd_data1;
    logic [2:0]    err1;

    int checks = 0;
    int errors = 0;

    always #5 wr_clk = ~wr_clk;

    sdpram_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1), .ERR_CNT_WIDTH(3)) dut0 (
        .wr_clk(wr_clk), .tb_wr_rst(tb_wr_rst), .start(start), .mode(mode),
        .ram_wr_en(wr_en0), .ram_wr_addr(wr_addr0), .ram_wr_data(wr_data0),
        .ram_rd_en(rd_en0), .ram_rd_addr(rd_addr0), .ram_rd_data(rd_data0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .first_err_addr(fea0)
    );

    sdpram_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2), .ERR_CNT_WIDTH(3)) dut1 (
        .wr_clk(wr_clk), .tb_wr_rst(tb_wr_rst), .start(start), .mode(mode),
        .ram_wr_en(wr_en1), .ram_wr_addr(wr_addr1), .ram_wr_data(wr_data1),
        .ram_rd_en(rd_en1), .ram_rd_addr(rd_addr1), .ram_rd_data(rd_data1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .first_err_addr(fea1)
    );

    // RAM models; model 0 has faults and a selectable output register, model 1 is ideal+registered
    logic [DW-1:0] mem0 [N];
    logic [DW-1:0] mem1 [N];
    logic [DW-1:0] raw0 = '0, regq0 = '0, raw1 = '0, regq1 = '0;
    bit            reg_out0   = 1'b0;
    bit            flip_en    = 1'b0;
    int            flip_a     = 0;
    int            flip_b     = 0;
    logic [DW-1:0] stuck_mask = '0;

    function automatic logic [DW-1:0] faulty(logic [DW-1:0] v, int a);
        logic [DW-1:0] r;
        r = v;
        if (flip_en && a == flip_a) r[flip_b] = ~r[flip_b];
        return r & ~stuck_mask;
    endfunction

    always @(posedge wr_clk) begin
        if (wr_en0) mem0[wr_addr0] <= wr_data0;
        if (rd_en0) raw0 <= faulty(mem0[rd_addr0], int'(rd_addr0));
        regq0 <= raw0;
        if (wr_en1) mem1[wr_addr1] <= wr_data1;
        if (rd_en1) raw1 <= mem1[rd_addr1];
        regq1 <= raw1;
    end

    assign rd_data0 = reg_out0 ? regq0 : raw0;
    assign rd_data1 = regq1;

    function automatic logic [DW-1:0] ref_pat(int md, int a);
        case (md)
            0:       return DW'((1 << DW) - 1 - a);
            1:       return DW'(a);
            2:       return (a % 2 == 0) ? 21'h155555 : 21'h0AAAAA;
            default: return DW'(1) << (a % DW);
        endcase
    endfunction

    // Outcome of a full run on model 0 given the current fault settings.
    function automatic exp_t predict(int md);
        exp_t e;
        int   cnt = 0;
        e.first = 0;
        for (int a = 0; a < N; a++) begin
            if (faulty(ref_pat(md, a), a) != ref_pat(md, a)) begin
                if (cnt == 0) e.first = a;
                cnt++;
            end
        end
        e.pass      = (cnt == 0);
        e.err       = (cnt > 7) ? 7 : cnt;
        e.chk_first = 1'b1;
        return e;
    endfunction

    task automatic check(string name, int d, longint unsigned act, longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", name, d, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard
    exp_t q0[$];
    exp_t q1[$];
    int   run_mode = 0;
    int   busy_c[2];
    int   wr_c[2];
    int   rd_c[2];
    bit   done_prev[2];

    task automatic mon(int d, logic we, logic [AW-1:0] wa, logic [DW-1:0] wd, logic re,
                       logic [AW-1:0] ra, logic bsy, logic dn, logic ps, logic [2:0] ec,
                       logic [AW-1:0] fa);
        exp_t e;
        bit   have;
        if (we) begin
            check("wr_addr", d, wa, wr_c[d]);
            check("wr_data", d, wd, ref_pat(run_mode, wr_c[d]));
            wr_c[d]++;
        end else begin
            check("wr_idle", d, {wa, wd}, 0);
        end
        if (re) begin
            check("rd_addr", d, ra, rd_c[d]);
            rd_c[d]++;
        end else begin
            check("rd_idle", d, ra, 0);
        end
        if (bsy) busy_c[d]++;
        if (dn && !done_prev[d]) begin
            have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
            check("done_expected", d, have, 1);
            if (have) begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                check("pass", d, ps, e.pass);
                check("err_cnt", d, ec, e.err);
                if (e.chk_first) check("first_err_addr", d, fa, e.first);
                check("busy_cycles", d, busy_c[d], 2 * N + 1 + (d + 1));
                check("wr_count", d, wr_c[d], N);
                check("rd_count", d, rd_c[d], N);
            end
            busy_c[d] = 0;
            wr_c[d]   = 0;
            rd_c[d]   = 0;
        end
        done_prev[d] = dn;
    endtask

    always @(negedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            for (int d = 0; d < 2; d++) begin
                busy_c[d]    = 0;
                wr_c[d]      = 0;
                rd_c[d]      = 0;
                done_prev[d] = 1'b0;
            end
            q0.delete();
            q1.delete();
        end else begin
            mon(0, wr_en0, wr_addr0, wr_data0, rd_en0, rd_addr0, busy0, done0, pass0, err0, fea0);
            mon(1, wr_en1, wr_addr1, wr_data1, rd_en1, rd_addr1, busy1, done1, pass1, err1, fea1);
        end
    end

    // Stimulus
    task automatic push_and_start(int md, exp_t e0);
        exp_t e1;
        e1 = '{pass: 1'b1, err: 0, first: 0, chk_first: 1'b1};
        q0.push_back(e0);
        q1.push_back(e1);
        run_mode = md;
        mode     = 2'(md);
        start    = 1'b1;
        @(posedge wr_clk); #1;
        start    = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!(done0 && done1) && n < 2000) begin
            @(posedge wr_clk); #1;
            n++;
        end
        check("run_timeout", 0, n < 2000, 1);
        @(negedge wr_clk);
        @(posedge wr_clk); #1;
    endtask

    task automatic run(int md, exp_t e0);
        push_and_start(md, e0);
        wait_done();
    endtask

    task automatic check_all_zero(string name);
        check({name, "_busy"}, 0, {busy0, busy1}, 0);
        check({name, "_done_pass"}, 0, {done0, pass0, done1, pass1}, 0);
        check({name, "_err"}, 0, {err0, fea0, err1, fea1}, 0);
        check({name, "_wr"}, 0, {wr_en0, wr_addr0, wr_data0, wr_en1}, 0);
        check({name, "_rd"}, 0, {rd_en0, rd_addr0, rd_en1, rd_addr1}, 0);
    endtask

    initial begin
        exp_t e;
        int   md;
        int   n;

        #1 tb_wr_rst = 1'b1;
        repeat (3) @(posedge wr_clk);
        #1;
        check_all_zero("reset");
        tb_wr_rst = 1'b0;
        @(posedge wr_clk); #1;

        // T1: ideal RAM, descending pattern
        run(0, predict(0));
        check("t1_mem0", 0, mem0[0], 21'h1FFFFF);
        check("t1_mem255", 0, mem0[255], 21'h1FFF00);

        // T2: single bit flip at 0x37
        flip_en = 1'b1; flip_a = 'h37; flip_b = 4;
        e = predict(0);
        check("t2_model", 0, {e.err, e.first}, {32'd1, 32'h37});
        run(0, e);
        flip_en = 1'b0;

        // T3: stuck-at-0 on bit 0 saturates the counter
        stuck_mask = 21'h1;
        run(0, predict(0));
        stuck_mask = '0;

        // T4: latency-1 controller against a registered-output RAM
        reg_out0 = 1'b1;
        e = '{pass: 1'b0, err: 7, first: 0, chk_first: 1'b0};
        run(0, e);
        reg_out0 = 1'b0;

        // T5: asynchronous reset mid-write
        md = int'($urandom_range(0, 3));
        push_and_start(md, predict(md));
        n = 0;
        while (!(wr_en0 && wr_addr0 == 8'h80) && n < 1000) begin
            @(posedge wr_clk); #1;
            n++;
        end
        check("t5_reach_0x80", 0, n < 1000, 1);
        tb_wr_rst = 1'b1;
        #1;
        check_all_zero("t5_async");
        #1 tb_wr_rst = 1'b0;
        @(posedge wr_clk); #1;
        run(md, predict(md));

        // T6: walking one, with a stray start during READ
        push_and_start(3, predict(3));
        n = 0;
        while (!rd_en0 && n < 1000) begin
            @(posedge wr_clk); #1;
            n++;
        end
        check("t6_reach_read", 0, n < 1000, 1);
        repeat (10) @(posedge wr_clk);
        #1;
        mode  = 2'd0;
        start = 1'b1;
        @(posedge wr_clk); #1;
        start = 1'b0;
        wait_done();
        check("t6_mem22", 0, mem0[22], 21'h000002);

        // Randomized runs with random faults
        for (int r = 0; r < 6; r++) begin
            md = int'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0: ;
                1: begin
                    flip_en = 1'b1;
                    flip_a  = int'($urandom_range(0, N - 1));
                    flip_b  = int'($urandom_range(0, DW - 1));
                end
                default: stuck_mask = DW'(1) << $urandom_range(0, DW - 1);
            endcase
            run(md, predict(md));
            flip_en    = 1'b0;
            stuck_mask = '0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
